// File: rtl/plot_stream_sink_pkg.sv
// Shared screen, grid and state definitions for the plot stream sink.
package plot_stream_sink_pkg;

  localparam int unsigned ScreenW   = 160;
  localparam int unsigned ScreenH   = 120;
  localparam int unsigned GridX0    = 50;
  localparam int unsigned GridY0    = 30;
  localparam int unsigned GridPitch = 20;
  localparam int unsigned NumCells  = 9;
  localparam logic [3:0]  CellNone  = 4'hF;

  typedef enum logic [1:0] {StIdle, StStream, StStall} sink_state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  // Returns 3*row+col of the 3x3 grid cell containing (x, y), or CellNone.
  function automatic logic [3:0] cell_index(input logic [7:0] x, input logic [6:0] y,
                                            input int unsigned cell_size);
    int unsigned xi, yi;
    logic [1:0]  col, row;
    logic        col_hit, row_hit;
    xi      = {24'd0, x};
    yi      = {25'd0, y};
    col     = 2'd0;
    row     = 2'd0;
    col_hit = 1'b0;
    row_hit = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (xi >= GridX0 + GridPitch * i && xi < GridX0 + GridPitch * i + cell_size) begin
        col_hit = 1'b1;
        col     = 2'(i);
      end
      if (yi >= GridY0 + GridPitch * i && yi < GridY0 + GridPitch * i + cell_size) begin
        row_hit = 1'b1;
        row     = 2'(i);
      end
    end
    if (col_hit && row_hit) begin
      cell_index = {2'b00, row} * 4'd3 + {2'b00, col};
    end else begin
      cell_index = CellNone;
    end
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Pixel FIFO: circular storage with wrapping pointers and an occupancy counter.
module plot_fifo
  import plot_stream_sink_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  pixel_t          wdata_i,
  output pixel_t          rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  pixel_t           mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CntW'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AddrW'(1);
      if (pop_i)  rptr_q <= rptr_q + AddrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only occupied entries are ever read.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/plot_stream_sink.sv
// Buffers pixel writes for the VGA adapter, drops off-screen pixels and keeps grid statistics.
module plot_stream_sink
  import plot_stream_sink_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CELL_SIZE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_x_i,
  input  logic [6:0] in_y_i,
  input  logic [2:0] in_colour_i,
  input  logic       out_stall_i,
  output logic       out_plot_o,
  output logic [7:0] out_x_o,
  output logic [6:0] out_y_o,
  output logic [2:0] out_colour_o,
  input  logic       clear_counts_i,
  input  logic [3:0] cell_sel_i,
  output logic [8:0] cell_pixels_o,
  output logic [8:0] cell_touched_o,
  output logic [7:0] drop_count_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            accept, in_range, push, pop, count_hit;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] occ, occ_next;
  logic [3:0]      pop_cell;
  pixel_t          in_pix, head_pix, out_pix_q;
  sink_state_e     state_q, state_d;
  logic            in_ready_q, out_plot_q;
  logic [8:0]      cell_cnt_q [NumCells];
  logic [8:0]      touched_q;
  logic [7:0]      drop_q;

  assign in_pix   = '{x: in_x_i, y: in_y_i, colour: in_colour_i};
  assign in_range = (in_x_i < 8'(ScreenW)) && (in_y_i < 7'(ScreenH));
  assign accept   = in_valid_i && in_ready_q;
  assign push     = accept && in_range;
  assign pop      = !fifo_empty && !out_stall_i;

  plot_fifo #(.Depth(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_pix),
    .rdata_o (head_pix),
    .count_o (occ),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    occ_next = occ;
    if (push && !pop) begin
      occ_next = occ + CntW'(1);
    end else if (pop && !push) begin
      occ_next = occ - CntW'(1);
    end
    if (occ_next == '0) begin
      state_d = StIdle;
    end else if (out_stall_i) begin
      state_d = StStall;
    end else begin
      state_d = StStream;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      out_plot_q <= 1'b0;
      out_pix_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (occ_next < CntW'(DEPTH));
      out_plot_q <= pop;
      if (pop) out_pix_q <= head_pix;
    end
  end

  assign pop_cell  = cell_index(head_pix.x, head_pix.y, CELL_SIZE);
  assign count_hit = pop && (pop_cell < 4'(NumCells)) && (head_pix.colour != 3'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q    <= '0;
      touched_q <= '0;
      for (int i = 0; i < NumCells; i++) cell_cnt_q[i] <= '0;
    end else begin
      if (accept && !in_range && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      // A clear overrides any count event landing on the same edge.
      if (clear_counts_i) begin
        touched_q <= '0;
        for (int i = 0; i < NumCells; i++) cell_cnt_q[i] <= '0;
      end else if (count_hit) begin
        touched_q[pop_cell] <= 1'b1;
        if (cell_cnt_q[pop_cell] != 9'h1FF) cell_cnt_q[pop_cell] <= cell_cnt_q[pop_cell] + 9'd1;
      end
    end
  end

  always_comb begin
    cell_pixels_o = '0;
    for (int i = 0; i < NumCells; i++) begin
      if (cell_sel_i == 4'(i)) cell_pixels_o = cell_cnt_q[i];
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_plot_o     = out_plot_q;
  assign out_x_o        = out_pix_q.x;
  assign out_y_o        = out_pix_q.y;
  assign out_colour_o   = out_pix_q.colour;
  assign cell_touched_o = touched_q;
  assign drop_count_o   = drop_q;

  assert property (@(posedge clk) disable iff (!reset_n) !(push && fifo_full));
  assert property (@(posedge clk) disable iff (!reset_n) (state_q == StIdle) == fifo_empty);

endmodule
